// File: rtl/enc164_req_latch_pkg.sv
// Shared types and sizes for the 16-to-4 request latch/encoder.
package enc_pkg;
    localparam int N_IN   = 16;
    localparam int CODE_W = 4;

    typedef enum logic {IDLE, PRESENT} enc_state_t;
    typedef logic [N_IN-1:0] req_vec_t;
endpackage

// File: rtl/prio_enc16.sv
// Combinational priority encoder: index of the highest set bit plus an any-set flag.
module prio_enc16
    import enc_pkg::*;
(
    input  req_vec_t          vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // Ascending scan, so the last hit is the highest index.
        for (int i = 0; i < N_IN; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/enc164_req_latch.sv
// Latches rising request edges into sticky pending bits and presents the
// highest pending index through a valid/ack handshake.
module enc164_req_latch
    import enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_IN-1:0]   req,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    input  logic              ack,
    output logic [N_IN-1:0]   pending,
    output logic              lost
);
    req_vec_t          req_q;
    req_vec_t          rise;
    req_vec_t          clr;
    req_vec_t          pend_nxt;
    enc_state_t        state;
    logic [CODE_W-1:0] top_idx;
    logic              top_any;

    prio_enc16 u_prio (
        .vec (pending),
        .idx (top_idx),
        .any (top_any)
    );

    // A rise in the same cycle as its own clear wins and is not counted as lost.
    always_comb begin
        rise = req & ~req_q & {N_IN{enable}};
        clr  = '0;
        if (state == PRESENT && ack)
            clr[code] = 1'b1;
        pend_nxt = (pending & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            pending <= '0;
            lost    <= 1'b0;
            code    <= '0;
            state   <= IDLE;
        end else begin
            req_q   <= req;
            pending <= pend_nxt;
            lost    <= |(rise & pending & ~clr);
            if (state == IDLE) begin
                if (top_any) begin
                    code  <= top_idx;
                    state <= PRESENT;
                end
            end else if (ack) begin
                state <= IDLE;
            end
        end
    end

    assign valid = (state == PRESENT);
endmodule

// File: tb/tb_enc164_req_latch.sv
// Directed plus randomized check of enc164_req_latch against a bit-array reference model.
module tb_enc164_req_latch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] req = '0;
    logic [3:0]  code;
    logic        valid;
    logic        ack = 1'b0;
    logic [15:0] pending;
    logic        lost;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit m_pend [16];
    bit m_prev [16];
    bit m_valid;
    int m_code;
    bit m_lost;

    enc164_req_latch dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .req     (req),
        .code    (code),
        .valid   (valid),
        .ack     (ack),
        .pending (pending),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_pend_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
        end
        m_valid = 0;
        m_code  = 0;
        m_lost  = 0;
    endtask

    // Advance the model by one clock using the inputs applied before the edge.
    task automatic model_clock(input logic [15:0] r, input bit en, input bit a);
        bit rise [16];
        bit clr_hit;
        bit any_old = 0;
        int hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_pend[i]) begin
                any_old = 1;
                hi = i;
            end
        end
        m_lost = 0;
        for (int i = 0; i < 16; i++) begin
            rise[i] = r[i] && !m_prev[i] && en;
            clr_hit = m_valid && a && (i == m_code);
            if (rise[i] && m_pend[i] && !clr_hit) m_lost = 1;
            m_pend[i] = rise[i] || (m_pend[i] && !clr_hit);
            m_prev[i] = r[i];
        end
        if (m_valid) begin
            if (a) m_valid = 0;
        end else if (any_old) begin
            m_valid = 1;
            m_code  = hi;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   valid,   m_valid);
        chk({tag, ".pending"}, pending, m_pend_vec());
        chk({tag, ".lost"},    lost,    m_lost);
        if (m_valid) chk({tag, ".code"}, code, m_code);
    endtask

    // Apply inputs now (just after an edge), clock once, then compare.
    task automatic step(input string tag, input logic [15:0] r, input bit en, input bit a);
        req = r;
        enable = en;
        ack = a;
        @(posedge clk);
        #1;
        model_clock(r, en, a);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst.code", code, 4'd0);
        chk("rst.valid", valid, 1'b0);
        chk("rst.pending", pending, 16'h0);
        chk("rst.lost", lost, 1'b0);
        rst_n = 1'b1;

        // single request
        step("t1a", 16'h0010, 1, 0);
        chk("t1.pend", pending, 16'h0010);
        step("t1b", 16'h0010, 1, 0);
        chk("t1.code", code, 4'd4);
        chk("t1.valid", valid, 1'b1);
        step("t1c", 16'h0010, 1, 1);
        chk("t1.drain", {15'd0, valid, pending}, 32'h0);

        // priority and ordering
        step("t2a", 16'h0000, 1, 0);
        step("t2b", 16'h8001, 1, 0);
        step("t2c", 16'h8001, 1, 0);
        chk("t2.code15", code, 4'd15);
        step("t2d", 16'h8001, 1, 1);
        chk("t2.idle", valid, 1'b0);
        step("t2e", 16'h8001, 1, 0);
        chk("t2.code0", code, 4'd0);
        step("t2f", 16'h8001, 1, 1);
        chk("t2.empty", pending, 16'h0);

        // no preemption
        step("t3a", 16'h0000, 1, 0);
        step("t3b", 16'h0008, 1, 0);
        step("t3c", 16'h0008, 1, 0);
        step("t3d", 16'h1008, 1, 0);
        step("t3e", 16'h1008, 1, 0);
        chk("t3.hold", code, 4'd3);
        step("t3f", 16'h1008, 1, 1);
        step("t3g", 16'h1008, 1, 0);
        chk("t3.next", code, 4'd12);
        step("t3h", 16'h1008, 1, 1);

        // set wins over clear on the same bit
        step("t4a", 16'h0000, 1, 0);
        step("t4b", 16'h0020, 1, 0);
        step("t4c", 16'h0020, 1, 0);
        step("t4d", 16'h0000, 1, 0);
        step("t4e", 16'h0020, 1, 1);
        chk("t4.kept", pending[5], 1'b1);
        chk("t4.nolost", lost, 1'b0);
        step("t4f", 16'h0020, 1, 0);
        chk("t4.repres", {valid, code}, {1'b1, 4'd5});
        step("t4g", 16'h0020, 1, 1);

        // lost pulse, then enable gating
        step("t5a", 16'h0000, 1, 0);
        step("t5b", 16'h0080, 1, 0);
        step("t5c", 16'h0080, 1, 0);
        step("t5d", 16'h0000, 1, 0);
        step("t5e", 16'h0080, 1, 0);
        chk("t5.lost", lost, 1'b1);
        step("t5f", 16'h0080, 1, 0);
        chk("t5.pulse", lost, 1'b0);
        step("t5g", 16'h0080, 1, 1);
        step("t5h", 16'h0200, 0, 0);
        chk("t5.gated", pending[9], 1'b0);
        step("t5i", 16'h0200, 1, 0);
        chk("t5.nostale", pending[9], 1'b0);

        // async reset mid-handshake
        step("t6a", 16'h0000, 1, 0);
        step("t6b", 16'h0400, 1, 0);
        step("t6c", 16'h0400, 1, 0);
        chk("t6.pre", valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6.valid", valid, 1'b0);
        chk("t6.code", code, 4'd0);
        chk("t6.pending", pending, 16'h0);
        chk("t6.lost", lost, 1'b0);
        req = '0;
        #2 rst_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [15:0] r;
            r = req ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            step("rnd", r, ($urandom % 8) != 0, ($urandom % 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
